mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the instruction-fetch (IF)
//  and data-memory (DM) requesters of the MIPS pipeline. Grants one

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-ported memory between IF and DM.
// Optional contention counter built only when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       contention_cnt
);

    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_EFF - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_dm_q, last_dm_d;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic              grant_if_s, grant_dm_s, final_s;

    // Under contention the requester that did not win last time is served.
    assign grant_dm_s = (state_q == IDLE) && dm_req && (!if_req || !last_dm_q);
    assign grant_if_s = (state_q == IDLE) && if_req && (!dm_req || last_dm_q);
    assign final_s    = (cnt_q == 4'd0);

    assign if_done   = (state_q == BUSY_IF) && final_s;
    assign dm_done   = (state_q == BUSY_DM) && final_s;
    assign if_rdata  = if_done ? mem_rdata : if_rdata_q;
    assign dm_rdata  = dm_done ? mem_rdata : dm_rdata_q;
    assign mem_sel   = sel_q;
    assign mem_en    = en_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Next-state and next-output computation for the access FSM
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        en_d      = en_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        last_dm_d = last_dm_q;
        case (state_q)
            IDLE: begin
                if (grant_dm_s) begin
                    state_d   = BUSY_DM;
                    sel_d     = 1'b1;
                    en_d      = 1'b1;
                    we_d      = dm_we;
                    addr_d    = dm_addr;
                    wdata_d   = dm_wdata;
                    cnt_d     = CNT_LOAD;
                    last_dm_d = 1'b1;
                end else if (grant_if_s) begin
                    state_d   = BUSY_IF;
                    sel_d     = 1'b0;
                    en_d      = 1'b1;
                    we_d      = 1'b0;
                    addr_d    = if_addr;
                    wdata_d   = '0;
                    cnt_d     = CNT_LOAD;
                    last_dm_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (final_s) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // FSM state and registered memory-side outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= 4'd0;
            last_dm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            last_dm_q <= last_dm_d;
        end
    end

    // Hold the last read data so the rdata outputs stay stable between accesses
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (if_done) begin
                if_rdata_q <= mem_rdata;
            end
            if (dm_done) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_q;
    logic        own_if_s, own_dm_s, waiting_s;

    assign own_if_s       = (state_q == BUSY_IF) || grant_if_s;
    assign own_dm_s       = (state_q == BUSY_DM) || grant_dm_s;
    assign waiting_s      = (if_req && !own_if_s) || (dm_req && !own_dm_s);
    assign contention_cnt = perf_q;

    // Saturating count of cycles in which some request is kept waiting
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            perf_q <= 16'h0000;
        end else if (waiting_s && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'h0001;
        end
    end
`else
    assign contention_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, access scoreboard and corner sequences.
module tb_mem_port_arbiter;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_done, dm_done, mem_sel, mem_en, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] contention_cnt;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b1;
    logic tb_last_dm = 1'b0;

    logic [31:0] tbmem [256];

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_dm_rdata;
    } vec_t;
    vec_t vecs[7];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Rst(Rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .contention_cnt(contention_cnt)
    );

    always #5 Clk = ~Clk;

    assign mem_rdata = tbmem[mem_addr[9:2]];

    always @(posedge Clk) begin
        if (mem_en && mem_we) tbmem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the next expected access
    always @(negedge Clk) begin
        if (mon_en && (if_done || dm_done)) begin
            exp_t e;
            if (if_done && dm_done) begin
                checks++; errors++;
                $display("FAIL both_done: got 1 expected 0");
            end
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got if=%b dm=%b expected none", if_done, dm_done);
            end else begin
                e = exp_q.pop_front();
                chk("done_owner", {31'd0, dm_done}, {31'd0, e.is_dm});
                chk("done_sel", {31'd0, mem_sel}, {31'd0, e.is_dm});
                chk("done_en", {31'd0, mem_en}, 32'd1);
                chk("done_we", {31'd0, mem_we}, {31'd0, e.we});
                chk("done_addr", mem_addr, e.addr);
                if (e.we) chk("done_wdata", mem_wdata, e.wdata);
                else if (e.is_dm) chk("dm_rdata", dm_rdata, e.rdata);
                else chk("if_rdata", if_rdata, e.rdata);
            end
        end
    end

    task automatic check_idle_outs(input string name);
        chk({name, "_ctl"}, {27'd0, if_done, dm_done, mem_sel, mem_en, mem_we}, 32'd0);
        chk({name, "_addr"}, mem_addr, 32'd0);
        chk({name, "_wdata"}, mem_wdata, 32'd0);
        chk({name, "_if_rdata"}, if_rdata, 32'd0);
        chk({name, "_dm_rdata"}, dm_rdata, 32'd0);
        chk({name, "_cnt"}, {16'd0, contention_cnt}, 32'd0);
    endtask

    task automatic push_if(input logic [31:0] a, input logic [31:0] rd);
        exp_t e;
        e.is_dm = 1'b0; e.we = 1'b0; e.addr = a; e.wdata = 32'd0; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic push_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd);
        exp_t e;
        e.is_dm = 1'b1; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic dm_first;
        int   lat_if, lat_dm;
        bit   pend_if, pend_dm;
        bit   both;
        both     = v.if_req && v.dm_req;
        dm_first = v.dm_req && (!v.if_req || !tb_last_dm);
        lat_if   = (both && dm_first) ? 2 * W + 1 : W;
        lat_dm   = (both && !dm_first) ? 2 * W + 1 : W;
        if (dm_first) begin
            push_dm(v.dm_we, v.dm_addr, v.dm_wdata, v.exp_dm_rdata);
            if (v.if_req) push_if(v.if_addr, v.exp_if_rdata);
        end else begin
            push_if(v.if_addr, v.exp_if_rdata);
            if (v.dm_req) push_dm(v.dm_we, v.dm_addr, v.dm_wdata, v.exp_dm_rdata);
        end
        tb_last_dm = both ? !dm_first : v.dm_req;
        @(negedge Clk);
        if_req = v.if_req; if_addr = v.if_addr;
        dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
        pend_if = v.if_req;
        pend_dm = v.dm_req;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                chk($sformatf("v%0d_en_c1", idx), {31'd0, mem_en}, 32'd1);
                chk($sformatf("v%0d_sel_c1", idx), {31'd0, mem_sel}, {31'd0, dm_first});
            end
            if (pend_if && if_done) begin
                chk($sformatf("v%0d_if_lat", idx), c, lat_if);
                pend_if = 1'b0; if_req = 1'b0;
            end
            if (pend_dm && dm_done) begin
                chk($sformatf("v%0d_dm_lat", idx), c, lat_dm);
                pend_dm = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
            end
            if (!pend_if && !pend_dm) break;
        end
        if (pend_if || pend_dm) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout: got pending if=%b dm=%b expected none", idx, pend_if, pend_dm);
            if_req = 1'b0; dm_req = 1'b0;
        end
        @(negedge Clk);
        chk($sformatf("v%0d_idle_gap", idx), {29'd0, mem_en, if_done, dm_done}, 32'd0);
    endtask

    initial begin
        vec_t   fv;
        logic [15:0] cnt0;
        for (int i = 0; i < 256; i++) tbmem[i] = 32'hA5A50000 | i;
        tbmem[16] = 32'h2402000A;
        Rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0;

        //          if_req  if_addr      dm_req dm_we dm_addr      dm_wdata      exp_if        exp_dm
        vecs[0] = '{1'b1, 32'h00000040, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h2402000A, 32'h0};
        vecs[1] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'h00000100, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[2] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000100, 32'h00000000, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b1, 32'h00000044, 1'b1, 1'b0, 32'h00000080, 32'h00000000, 32'hA5A50011, 32'hA5A50020};
        vecs[4] = '{1'b1, 32'h00000048, 1'b1, 1'b1, 32'h00000200, 32'h12345678, 32'hA5A50012, 32'h0};
        vecs[5] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000200, 32'h00000000, 32'h0,        32'h12345678};
        vecs[6] = '{1'b1, 32'h00000200, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h12345678, 32'h0};

        // Reset held, then released: everything zero and quiet
        repeat (2) @(negedge Clk);
        check_idle_outs("rst_hold");
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check_idle_outs("post_rst");
        end

        // Sustained contention: DM, IF, DM, IF three cycles apart
        for (int k = 0; k < 2; k++) begin
            push_dm(1'b0, 32'h00000104, 32'd0, 32'hA5A50041);
            push_if(32'h00000040, 32'h2402000A);
        end
        @(negedge Clk);
        cnt0 = contention_cnt;
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            chk($sformatf("rr_dm_done_c%0d", c), {31'd0, dm_done}, {31'd0, (c == 2 || c == 8)});
            chk($sformatf("rr_if_done_c%0d", c), {31'd0, if_done}, {31'd0, (c == 5 || c == 11)});
        end
`ifdef ARB_PERF_CNT_EN
        chk("rr_contention_delta", {16'd0, contention_cnt - cnt0}, 32'd12);
`else
        chk("rr_contention_off", {16'd0, contention_cnt}, {16'd0, cnt0});
`endif
        if_req = 1'b0; dm_req = 1'b0;
        tb_last_dm = 1'b0;
        @(negedge Clk);
        chk("rr_queue_empty", exp_q.size(), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset during a DM write aborts it with no done pulse
        @(negedge Clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hCAFEF00D;
        @(negedge Clk);
        chk("abort_busy", {30'd0, mem_en, mem_we}, 32'd3);
        Rst = 1'b1;
        #1;
        chk("abort_drop", {29'd0, mem_en, mem_we, dm_done}, 32'd0);
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge Clk);
        chk("abort_nodone", {31'd0, dm_done}, 32'd0);
        Rst = 1'b0;
        tb_last_dm = 1'b0;
        fv = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h00000300, 32'h0BADF00D, 32'h0, 32'h0};
        run_vec(fv, 7);
        fv = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h00000300, 32'h0, 32'h0, 32'h0BADF00D};
        run_vec(fv, 8);
        chk("sb_queue_empty", exp_q.size(), 32'd0);

        // Long contention: counter saturates, or stays zero when not built
        mon_en = 1'b0;
        @(negedge Clk);
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
`ifdef ARB_PERF_CNT_EN
        repeat (70000) @(negedge Clk);
        chk("perf_saturate", {16'd0, contention_cnt}, 32'h0000FFFF);
        repeat (10) @(negedge Clk);
        chk("perf_hold", {16'd0, contention_cnt}, 32'h0000FFFF);
`else
        repeat (200) @(negedge Clk);
        chk("perf_disabled", {16'd0, contention_cnt}, 32'd0);
`endif
        if_req = 1'b0; dm_req = 1'b0;
        repeat (10) @(negedge Clk);
        chk("final_idle_en", {31'd0, mem_en}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
